// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RAW = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_src1_sel,
  input  logic             id_src2_sel,
  input  logic [3:0]       id_alu_func,
  input  logic [RAW-1:0]   id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             exmem_we,
  input  logic [RAW-1:0]   exmem_rd,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_we,
  input  logic [RAW-1:0]   memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_func,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [RAW-1:0]   ex_rd,
  output logic             ex_we,
  output logic             ex_is_load,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             lu_stall
);
  logic             valid_q, valid_d, we_q, we_d, is_load_q, is_load_d;
  logic             rs1_used_q, rs1_used_d, rs2_used_q, rs2_used_d;
  logic             src1_sel_q, src1_sel_d, src2_sel_q, src2_sel_d;
  logic [WIDTH-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [WIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [RAW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic             bubble;
  always_comb begin
    fwd_rs1 = !rs1_used_q || rs1_q == '0 ? rs1_data_q :
              exmem_we && exmem_rd == rs1_q ? exmem_data :
              memwb_we && memwb_rd == rs1_q ? memwb_data : rs1_data_q;
    fwd_rs2 = !rs2_used_q || rs2_q == '0 ? rs2_data_q :
              exmem_we && exmem_rd == rs2_q ? exmem_data :
              memwb_we && memwb_rd == rs2_q ? memwb_data : rs2_data_q;
    lu_stall = id_valid && valid_q && is_load_q && we_q && rd_q != '0 &&
               ((id_rs1_used && id_rs1 == rd_q) || (id_rs2_used && id_rs2 == rd_q));
    bubble = flush || (!stall && lu_stall);
  end
  always_comb begin
    valid_d = valid_q; pc_d = pc_q; rs1_d = rs1_q; rs2_d = rs2_q;
    rs1_used_d = rs1_used_q; rs2_used_d = rs2_used_q;
    rs1_data_d = rs1_data_q; rs2_data_d = rs2_data_q; imm_d = imm_q;
    src1_sel_d = src1_sel_q; src2_sel_d = src2_sel_q; func_d = func_q;
    rd_d = rd_q; we_d = we_q; is_load_d = is_load_q;
    if (bubble) begin
      valid_d = 1'b0; pc_d = '0; rs1_d = '0; rs2_d = '0;
      rs1_used_d = 1'b0; rs2_used_d = 1'b0;
      rs1_data_d = '0; rs2_data_d = '0; imm_d = '0;
      src1_sel_d = 1'b0; src2_sel_d = 1'b0; func_d = '0;
      rd_d = '0; we_d = 1'b0; is_load_d = 1'b0;
    end else if (stall) begin
      // keep forwarded values alive while their producers drain out of the pipe
      rs1_data_d = fwd_rs1; rs2_data_d = fwd_rs2;
    end else begin
      valid_d = id_valid; pc_d = id_pc; rs1_d = id_rs1; rs2_d = id_rs2;
      rs1_used_d = id_rs1_used; rs2_used_d = id_rs2_used;
      rs1_data_d = id_rs1_data; rs2_data_d = id_rs2_data; imm_d = id_imm;
      src1_sel_d = id_src1_sel; src2_sel_d = id_src2_sel; func_d = id_alu_func;
      rd_d = id_rd; we_d = id_we; is_load_d = id_is_load;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0;
      rs1_used_q <= 1'b0; rs2_used_q <= 1'b0;
      rs1_data_q <= '0; rs2_data_q <= '0; imm_q <= '0;
      src1_sel_q <= 1'b0; src2_sel_q <= 1'b0; func_q <= '0;
      rd_q <= '0; we_q <= 1'b0; is_load_q <= 1'b0;
    end else begin
      valid_q <= valid_d; pc_q <= pc_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
      rs1_used_q <= rs1_used_d; rs2_used_q <= rs2_used_d;
      rs1_data_q <= rs1_data_d; rs2_data_q <= rs2_data_d; imm_q <= imm_d;
      src1_sel_q <= src1_sel_d; src2_sel_q <= src2_sel_d; func_q <= func_d;
      rd_q <= rd_d; we_q <= we_d; is_load_q <= is_load_d;
    end
  end
  assign alu_src1 = src1_sel_q ? pc_q : fwd_rs1;
  assign alu_src2 = src2_sel_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_func = func_q;
  assign ex_valid = valid_q;
  assign ex_pc = pc_q;
  assign ex_rd = rd_q;
  assign ex_we = we_q;
  assign ex_is_load = is_load_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed tests of capture, forwarding, load-use bubble, stall refresh and flush
module tb_ex_operand_stage;
  logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        id_valid, id_rs1_used, id_rs2_used, id_src1_sel, id_src2_sel, id_we, id_is_load;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_func;
  logic        exmem_we = 1'b0, memwb_we = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_data = '0, memwb_data = '0;
  logic [31:0] alu_src1, alu_src2, ex_pc, ex_store_data;
  logic [3:0]  alu_func;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_we, ex_is_load, lu_stall;
  int checks = 0, errors = 0;

  ex_operand_stage #(.WIDTH(32), .RAW(5)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel), .id_alu_func(id_alu_func),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_func(alu_func),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_store_data(ex_store_data), .lu_stall(lu_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic u2,
                        input logic [31:0] d2, input logic [31:0] imm, input logic s1,
                        input logic s2, input logic [3:0] fn, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs1_used = u1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_used = u2; id_rs2_data = d2; id_imm = imm;
    id_src1_sel = s1; id_src2_sel = s2; id_alu_func = fn; id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  task automatic test_reset();
    set_id(32'h100, 5'd1, 1, 32'h10, 5'd2, 1, 32'h20, 32'h30, 0, 0, 4'h3, 5'd9, 1, 0);
    rstn = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", ex_valid); end
    checks++; if (alu_func !== 4'h0) begin errors++; $display("FAIL rst_func got %h exp 0", alu_func); end
    checks++; if ({alu_src1, alu_src2, ex_pc, ex_store_data} !== '0) begin errors++; $display("FAIL rst_data got %h %h %h %h exp 0", alu_src1, alu_src2, ex_pc, ex_store_data); end
    checks++; if ({ex_rd, ex_we, ex_is_load, lu_stall} !== '0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", {ex_rd, ex_we, ex_is_load, lu_stall}); end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd9 || ex_we !== 1'b1) begin errors++; $display("FAIL cap_ctrl got v%h pc%h rd%h we%h exp v1 pc100 rd9 we1", ex_valid, ex_pc, ex_rd, ex_we); end
    checks++; if (alu_src1 !== 32'h10 || alu_src2 !== 32'h20 || alu_func !== 4'h3) begin errors++; $display("FAIL cap_ops got %h %h %h exp 10 20 3", alu_src1, alu_src2, alu_func); end
    checks++; if (ex_store_data !== 32'h20) begin errors++; $display("FAIL cap_store got %h exp 20", ex_store_data); end
  endtask

  task automatic test_fwd_priority();
    set_id(32'h200, 5'd5, 1, 32'h99, 5'd6, 1, 32'h66, 32'h0, 0, 0, 4'h1, 5'd8, 1, 0);
    tick();
    exmem_we = 1; exmem_rd = 5'd5; exmem_data = 32'h11;
    memwb_we = 1; memwb_rd = 5'd5; memwb_data = 32'h22;
    #1;
    checks++; if (alu_src1 !== 32'h11) begin errors++; $display("FAIL fwd_exmem got %h exp 11", alu_src1); end
    checks++; if (alu_src2 !== 32'h66) begin errors++; $display("FAIL fwd_nomatch got %h exp 66", alu_src2); end
    exmem_we = 0;
    #1;
    checks++; if (alu_src1 !== 32'h22) begin errors++; $display("FAIL fwd_memwb got %h exp 22", alu_src1); end
    memwb_rd = 5'd6;
    #1;
    checks++; if (alu_src1 !== 32'h99 || ex_store_data !== 32'h22) begin errors++; $display("FAIL fwd_rs2 got %h %h exp 99 22", alu_src1, ex_store_data); end
    memwb_we = 0;
  endtask

  task automatic test_x0();
    set_id(32'h300, 5'd1, 0, 32'h0, 5'd0, 1, 32'h0, 32'h0, 0, 0, 4'h2, 5'd1, 1, 0);
    tick();
    exmem_we = 1; exmem_rd = 5'd0; exmem_data = 32'hFF;
    #1;
    checks++; if (alu_src2 !== 32'h0 || ex_store_data !== 32'h0) begin errors++; $display("FAIL x0_fwd got %h %h exp 0 0", alu_src2, ex_store_data); end
    set_id(32'h304, 5'd1, 0, 32'h0, 5'd0, 1, 32'h0, 32'h7, 0, 1, 4'h2, 5'd1, 1, 0);
    tick();
    checks++; if (alu_src2 !== 32'h7) begin errors++; $display("FAIL x0_imm got %h exp 7", alu_src2); end
    set_id(32'h308, 5'd1, 0, 32'h0, 5'd0, 0, 32'h0, 32'h0, 1, 0, 4'h2, 5'd1, 1, 0);
    tick();
    checks++; if (alu_src1 !== 32'h308) begin errors++; $display("FAIL src1_pc got %h exp 308", alu_src1); end
    exmem_we = 0;
  endtask

  task automatic test_load_use();
    set_id(32'h400, 5'd2, 1, 32'h0, 5'd0, 0, 32'h0, 32'h4, 0, 1, 4'h0, 5'd3, 1, 1);
    tick();
    set_id(32'h404, 5'd3, 1, 32'h0, 5'd1, 1, 32'h5, 32'h0, 0, 0, 4'h0, 5'd4, 1, 0);
    id_valid = 0;
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL lu_idvalid got %h exp 0", lu_stall); end
    id_valid = 1;
    #1;
    checks++; if (lu_stall !== 1'b1) begin errors++; $display("FAIL lu_detect got %h exp 1", lu_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || alu_src1 !== 32'h0 || alu_src2 !== 32'h0 || ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble got v%h %h %h rd%h exp 0", ex_valid, alu_src1, alu_src2, ex_rd); end
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL lu_clear got %h exp 0", lu_stall); end
    tick();
    memwb_we = 1; memwb_rd = 5'd3; memwb_data = 32'hAB;
    #1;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || alu_src1 !== 32'hAB || alu_src2 !== 32'h5) begin errors++; $display("FAIL lu_fwd got v%h rd%h %h %h exp 1 4 ab 5", ex_valid, ex_rd, alu_src1, alu_src2); end
    memwb_we = 0;
  endtask

  task automatic test_lu_vs_stall();
    set_id(32'h500, 5'd2, 1, 32'h0, 5'd0, 0, 32'h0, 32'h4, 0, 1, 4'h0, 5'd3, 1, 1);
    tick();
    set_id(32'h504, 5'd0, 0, 32'h0, 5'd3, 1, 32'h0, 32'h0, 0, 0, 4'h6, 5'd4, 1, 0);
    stall = 1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_pc !== 32'h500 || lu_stall !== 1'b1) begin errors++; $display("FAIL stall_over_lu got v%h ld%h pc%h lu%h exp 1 1 500 1", ex_valid, ex_is_load, ex_pc, lu_stall); end
    stall = 0;
  endtask

  task automatic test_stall_refresh();
    set_id(32'h600, 5'd7, 1, 32'h1, 5'd0, 0, 32'h0, 32'h0, 0, 0, 4'h5, 5'd8, 1, 0);
    tick();
    stall = 1; memwb_we = 1; memwb_rd = 5'd7; memwb_data = 32'h55;
    set_id(32'h700, 5'd9, 1, 32'h77, 5'd0, 0, 32'h0, 32'h0, 1, 0, 4'hA, 5'd10, 1, 0);
    #1;
    checks++; if (alu_src1 !== 32'h55) begin errors++; $display("FAIL refresh_c1 got %h exp 55", alu_src1); end
    tick();
    memwb_we = 0;
    #1;
    checks++; if (alu_src1 !== 32'h55 || alu_func !== 4'h5 || ex_pc !== 32'h600) begin errors++; $display("FAIL refresh_c2 got %h %h %h exp 55 5 600", alu_src1, alu_func, ex_pc); end
    tick();
    checks++; if (alu_src1 !== 32'h55 || ex_rd !== 5'd8) begin errors++; $display("FAIL refresh_c3 got %h rd%h exp 55 8", alu_src1, ex_rd); end
    stall = 0;
  endtask

  task automatic test_flush();
    stall = 1; flush = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || alu_func !== 4'h0 || alu_src1 !== 32'h0 || alu_src2 !== 32'h0) begin errors++; $display("FAIL flush got v%h f%h %h %h exp 0", ex_valid, alu_func, alu_src1, alu_src2); end
    stall = 0; flush = 0;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h700 || alu_func !== 4'hA) begin errors++; $display("FAIL post_flush got v%h pc%h f%h exp 1 700 a", ex_valid, ex_pc, alu_func); end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_lu_vs_stall();
    test_stall_refresh();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
